// File: rtl/skinny_sbox8_dom1_drv.sv
// Masks a byte into two shares, feeds the DOM S-box and returns the captured result shares.
// Latency: result valid LAT+1 cycles after accept; one byte per LAT+3 cycles at best.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready.
module skinny_sbox8_dom1_drv #(
  parameter int unsigned LAT  = 4,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic [7:0] sbox_in0,
  output logic [7:0] sbox_in1,
  output logic [7:0] sbox_r,
  input  logic [7:0] sbox_out0,
  input  logic [7:0] sbox_out1,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_s0,
  output logic [7:0] out_s1
);

  localparam int unsigned   CW       = $clog2(LAT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(LAT);
  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [15:0]   SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [7:0]    sbox_in0_q, sbox_in0_d;
  logic [7:0]    sbox_in1_q, sbox_in1_d;
  logic [7:0]    sbox_r_q, sbox_r_d;
  logic [7:0]    out_s0_q, out_s0_d;
  logic [7:0]    out_s1_q, out_s1_d;
  logic          out_valid_q, out_valid_d;
  logic          in_ready_q, in_ready_d;
  logic          lfsr_fb;

  // Next-state logic: load shares on accept, count the S-box latency, hold the result until taken.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lfsr_d      = lfsr_q;
    sbox_in0_d  = sbox_in0_q;
    sbox_in1_d  = sbox_in1_q;
    sbox_r_d    = sbox_r_q;
    out_s0_d    = out_s0_q;
    out_s1_d    = out_s1_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    lfsr_fb     = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    case (state_q)
      IDLE: begin
        // in_ready_q is always 1 here, so in_valid alone completes the handshake.
        if (in_valid) begin
          sbox_in0_d = in_data ^ lfsr_q[7:0];
          sbox_in1_d = lfsr_q[7:0];
          sbox_r_d   = lfsr_q[15:8];
          lfsr_d     = {lfsr_q[14:0], lfsr_fb};
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == CNT_LAST) begin
          // S-box outputs have been settled for a full cycle; sample them.
          out_s0_d    = sbox_out0;
          out_s1_d    = sbox_out1;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        // in_ready rises only after this edge, so no accept can share it.
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // State and registered outputs; reset discards any pending result and reloads the seed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lfsr_q      <= SEED_EFF;
      sbox_in0_q  <= 8'h00;
      sbox_in1_q  <= 8'h00;
      sbox_r_q    <= 8'h00;
      out_s0_q    <= 8'h00;
      out_s1_q    <= 8'h00;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lfsr_q      <= lfsr_d;
      sbox_in0_q  <= sbox_in0_d;
      sbox_in1_q  <= sbox_in1_d;
      sbox_r_q    <= sbox_r_d;
      out_s0_q    <= out_s0_d;
      out_s1_q    <= out_s1_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign sbox_in0  = sbox_in0_q;
  assign sbox_in1  = sbox_in1_q;
  assign sbox_r    = sbox_r_q;
  assign out_valid = out_valid_q;
  assign out_s0    = out_s0_q;
  assign out_s1    = out_s1_q;

endmodule

// File: tb/tb_skinny_sbox8_dom1_drv.sv
// Bench for skinny_sbox8_dom1_drv: stands in for the masked S-box with a LAT-deep delay line.
// Expected results come from a bit-level SKINNY S8 construction and a plain LFSR model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_skinny_sbox8_dom1_drv;

  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [7:0] sbox_in0, sbox_in1, sbox_r;
  logic [7:0] sbox_out0, sbox_out1;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_s0, out_s1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [15:0] model_lfsr;
  logic [7:0]  exp_in0, exp_in1, exp_r, last_d;
  int          acc_cyc;

  skinny_sbox8_dom1_drv #(.LAT(LAT), .SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .sbox_in0(sbox_in0), .sbox_in1(sbox_in1), .sbox_r(sbox_r),
    .sbox_out0(sbox_out0), .sbox_out1(sbox_out1),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_s0(out_s0), .out_s1(out_s1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SKINNY 8-bit S-box built from its NOR/XOR mixing layers and bit permutations.
  function automatic logic [7:0] sk_mix(input logic [7:0] x);
    logic [7:0] t;
    t = (x >> 1) | x;
    t = t >> 2;
    t = ~t;
    return (t & 8'h11) ^ x;
  endfunction

  function automatic logic [7:0] sk_perm(input logic [7:0] x);
    logic [7:0] a, b, c, d, e;
    a = (x & 8'h01) << 2;
    b = (x & 8'h06) << 5;
    c = (x & 8'h20) >> 5;
    d = (x & 8'hC8) >> 2;
    e = (x & 8'h10) >> 1;
    return a | b | c | d | e;
  endfunction

  function automatic logic [7:0] s8(input logic [7:0] x);
    logic [7:0] y;
    y = sk_mix(x);
    y = sk_perm(y); y = sk_mix(y);
    y = sk_perm(y); y = sk_mix(y);
    y = sk_perm(y); y = sk_mix(y);
    return (y & 8'hF9) | ((y >> 1) & 8'h02) | ((y << 1) & 8'h04);
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // S-box stand-in: any sharing of S8(x) works; outputs reflect inputs only after LAT edges.
  function automatic logic [15:0] sbox_fn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] r);
    logic [7:0] o1;
    o1 = r ^ {b[3:0], b[7:4]};
    return {s8(a ^ b) ^ o1, o1};
  endfunction

  logic [15:0] pipe [LAT];
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= sbox_fn(sbox_in0, sbox_in1, sbox_r);
  end
  assign sbox_out0 = pipe[LAT-1][15:8];
  assign sbox_out1 = pipe[LAT-1][7:0];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Present a byte, wait (bounded) for in_ready, and check the loaded shares against the model.
  task automatic accept(input logic [7:0] d);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (in_ready !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("accept_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    exp_in1    = model_lfsr[7:0];
    exp_r      = model_lfsr[15:8];
    exp_in0    = d ^ model_lfsr[7:0];
    model_lfsr = lfsr_step(model_lfsr);
    last_d     = d;
    @(negedge clk);
    in_valid = 1'b0;
    acc_cyc  = cyc;
    chk("acc_in0", sbox_in0, exp_in0);
    chk("acc_in1", sbox_in1, exp_in1);
    chk("acc_r", sbox_r, exp_r);
    chk("acc_in_ready", in_ready, 0);
  endtask

  // Count cycles to out_valid; shares must stay put and in_valid noise must be ignored.
  task automatic wait_valid(input bit noise);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 30) begin
      if (noise) begin
        in_valid = 1'b1;
        in_data  = 8'($urandom);
      end
      @(negedge clk);
      n++;
      chk("hold_in0", sbox_in0, exp_in0);
      chk("hold_in1", sbox_in1, exp_in1);
      chk("hold_r", sbox_r, exp_r);
      chk("busy_in_ready", in_ready, 0);
    end
    chk("latency", n, LAT + 1);
  endtask

  // mode 0: out_ready high, 1: random out_ready, 2: stall 20 cycles then release.
  task automatic drain(input int mode, input bit noise);
    logic [7:0] s0, s1;
    logic       r;
    int         n;
    s0 = out_s0;
    s1 = out_s1;
    r  = 1'b0;
    chk("result_xor", s0 ^ s1, s8(last_d));
    n = 0;
    while (n < 300) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = 1'($urandom_range(0, 1));
        default: r = (n >= 20);
      endcase
      out_ready = r;
      if (noise) begin
        in_valid = 1'b1;
        in_data  = 8'($urandom);
      end
      @(negedge clk);
      n++;
      if (r) break;
      chk("stall_valid", out_valid, 1);
      chk("stall_s0", out_s0, s0);
      chk("stall_s1", out_s1, s1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_in0", sbox_in0, exp_in0);
    end
    in_valid = 1'b0;
    chk("hs_valid", out_valid, 0);
    chk("hs_in_ready", in_ready, 1);
    chk("keep_s0", out_s0, s0);
    chk("keep_s1", out_s1, s1);
    chk("keep_in0", sbox_in0, exp_in0);
  endtask

  typedef struct {
    logic [7:0] d;
    logic [7:0] in0;
    logic [7:0] in1;
    logic [7:0] r;
    logic [7:0] s;
  } vec_t;

  initial begin
    vec_t tbl [3];
    int   prev;
    bit   nz;

    tbl[0] = '{d: 8'h00, in0: 8'hE1, in1: 8'hE1, r: 8'hAC, s: 8'h65};
    tbl[1] = '{d: 8'hFF, in0: 8'h3C, in1: 8'hC3, r: 8'h59, s: 8'hFF};
    tbl[2] = '{d: 8'h00, in0: 8'h87, in1: 8'h87, r: 8'hB3, s: 8'h65};

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    model_lfsr = 16'hACE1;
    #1;
    chk("rst_in0", sbox_in0, 0);
    chk("rst_in1", sbox_in1, 0);
    chk("rst_r", sbox_r, 0);
    chk("rst_s0", out_s0, 0);
    chk("rst_s1", out_s1, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Back-to-back known vectors with out_ready held high.
    prev = 0;
    for (int i = 0; i < 3; i++) begin
      accept(tbl[i].d);
      chk("vec_in0", sbox_in0, tbl[i].in0);
      chk("vec_in1", sbox_in1, tbl[i].in1);
      chk("vec_r", sbox_r, tbl[i].r);
      if (i > 0) chk("vec_spacing", acc_cyc - prev, LAT + 3);
      prev = acc_cyc;
      wait_valid(1'b0);
      chk("vec_xor", out_s0 ^ out_s1, tbl[i].s);
      drain(0, 1'b0);
    end

    // in_valid held with toggling data through BUSY/DONE; next byte taken at the first IDLE cycle.
    accept(8'h5A);
    wait_valid(1'b1);
    drain(0, 1'b1);
    prev = acc_cyc;
    accept(8'hA5);
    chk("noise_spacing", acc_cyc - prev, LAT + 3);
    wait_valid(1'b0);
    drain(2, 1'b0);

    // Exhaustive byte sweep with random backpressure and random input noise.
    for (int d = 0; d < 256; d++) begin
      nz = 1'($urandom_range(0, 1));
      accept(8'(d));
      wait_valid(nz);
      drain(1, nz);
    end

    // Reset in the middle of BUSY.
    accept(8'h11);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rbusy_out_valid", out_valid, 0);
    chk("rbusy_in_ready", in_ready, 1);
    chk("rbusy_in0", sbox_in0, 0);
    chk("rbusy_r", sbox_r, 0);
    @(negedge clk);
    rst = 1'b0;
    model_lfsr = 16'hACE1;
    accept(8'h00);
    chk("rbusy_next_in0", sbox_in0, 8'hE1);
    chk("rbusy_next_r", sbox_r, 8'hAC);
    wait_valid(1'b0);

    // Reset while a result waits in DONE.
    #2 rst = 1'b1;
    #1;
    chk("rdone_out_valid", out_valid, 0);
    chk("rdone_in_ready", in_ready, 1);
    chk("rdone_s0", out_s0, 0);
    chk("rdone_s1", out_s1, 0);
    @(negedge clk);
    rst = 1'b0;
    model_lfsr = 16'hACE1;
    accept(8'h00);
    chk("rdone_next_in0", sbox_in0, 8'hE1);
    chk("rdone_next_r", sbox_r, 8'hAC);
    wait_valid(1'b0);
    drain(0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete (checks %0d, errors %0d)", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
